// File: rtl/mac_pkg.sv
// Shared sizing helpers and the output finishing function (round, shift,
// saturate, ReLU) for the folded signed matrix-vector MAC.
package mac_pkg;

  typedef logic signed [63:0] wide_t;

  function automatic int acc_width(input int width, input int size_a);
    return 2 * width + $clog2(size_a);
  endfunction

  function automatic int beat_count(input int size_a, input int lanes);
    return size_a / lanes;
  endfunction

  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // x arrives sign-extended from accw bits; rounding wraps at accw like the datapath.
  function automatic wide_t fin(input wide_t x, input int accw, input int shift,
                                input int owidth, input logic relu);
    wide_t y;
    wide_t hi;
    wide_t lo;
    y = x;
    if (shift > 0) begin
      y = y + (64'sd1 <<< (shift - 1));
      y = (y <<< (64 - accw)) >>> (64 - accw);
    end
    y  = y >>> shift;
    hi = (64'sd1 <<< (owidth - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (y > hi) begin
      y = hi;
    end else if (y < lo) begin
      y = lo;
    end
    if (relu && (y < 0)) begin
      y = '0;
    end
    return y;
  endfunction

endpackage

// File: rtl/mac_lane_dot.sv
// Combinational signed dot product of one weight row with one activation beat.
module mac_lane_dot #(
  parameter int LANES = 4,
  parameter int WIDTH = 4,
  parameter int ACCW  = 13
) (
  input  logic [LANES*WIDTH-1:0] w_i,
  input  logic [LANES*WIDTH-1:0] s_i,
  output logic signed [ACCW-1:0] dot_o
);

  logic signed [ACCW-1:0] prod [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_prod
    assign prod[l] = ACCW'($signed(w_i[l*WIDTH +: WIDTH])) *
                     ACCW'($signed(s_i[l*WIDTH +: WIDTH]));
  end

  always_comb begin
    dot_o = '0;
    for (int l = 0; l < LANES; l++) begin
      dot_o = dot_o + prod[l];
    end
  end

endmodule

// File: rtl/mac_folded.sv
// Folded signed matrix-vector MAC: SIZE_B rows accumulate LANES products per
// beat over SIZE_A/LANES beats, then finish into a back-pressurable register.
module mac_folded
  import mac_pkg::*;
#(
  parameter int SIZE_A = 32,
  parameter int SIZE_B = 32,
  parameter int LANES  = 4,
  parameter int WIDTH  = 4,
  parameter int OWIDTH = 8,
  parameter int SHIFT  = 0,
  parameter int RELU   = 0
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iValid_AM_W,
  output logic                      oReady_AM_W,
  input  logic [SIZE_B*LANES*WIDTH-1:0] iData_AM_W,
  input  logic                      iValid_AM_S,
  output logic                      oReady_AM_S,
  input  logic [LANES*WIDTH-1:0]    iData_AM_S,
  output logic                      oValid_BM_WS,
  input  logic                      iReady_BM_WS,
  output logic [SIZE_B*OWIDTH-1:0]  oData_BM_WS
);

  localparam int ACCW  = acc_width(WIDTH, SIZE_A);
  localparam int BEATS = beat_count(SIZE_A, LANES);
  localparam int CNTW  = cnt_width(BEATS);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(BEATS - 1);

  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic signed [ACCW-1:0]   acc_q [SIZE_B];
  logic signed [ACCW-1:0]   acc_d [SIZE_B];
  logic signed [ACCW-1:0]   dot   [SIZE_B];
  logic signed [ACCW-1:0]   sum   [SIZE_B];
  logic                     out_valid_q, out_valid_d;
  logic [SIZE_B*OWIDTH-1:0] out_data_q, out_data_d;
  logic                     last, can_accept, accept;

  // Only a last beat needs the output register free; earlier beats keep flowing.
  assign last        = (cnt_q == LAST_CNT);
  assign can_accept  = ~last | ~out_valid_q | iReady_BM_WS;
  assign oReady_AM_W = iValid_AM_S & can_accept;
  assign oReady_AM_S = iValid_AM_W & can_accept;
  assign accept      = iValid_AM_W & iValid_AM_S & can_accept;

  for (genvar b = 0; b < SIZE_B; b++) begin : g_row
    mac_lane_dot #(
      .LANES(LANES),
      .WIDTH(WIDTH),
      .ACCW (ACCW)
    ) u_dot (
      .w_i  (iData_AM_W[b*LANES*WIDTH +: LANES*WIDTH]),
      .s_i  (iData_AM_S),
      .dot_o(dot[b])
    );
    assign sum[b] = acc_q[b] + dot[b];
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    for (int b = 0; b < SIZE_B; b++) begin
      acc_d[b] = acc_q[b];
    end
    if (out_valid_q && iReady_BM_WS) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (last) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        for (int b = 0; b < SIZE_B; b++) begin
          acc_d[b] = '0;
          out_data_d[b*OWIDTH +: OWIDTH] =
            OWIDTH'(fin(64'(sum[b]), ACCW, SHIFT, OWIDTH, RELU != 0));
        end
      end else begin
        cnt_d = cnt_q + CNTW'(1);
        for (int b = 0; b < SIZE_B; b++) begin
          acc_d[b] = sum[b];
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      // NOTE: accumulators are reset too, so a half-built vector never leaks into the next one.
      for (int b = 0; b < SIZE_B; b++) begin
        acc_q[b] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int b = 0; b < SIZE_B; b++) begin
        acc_q[b] <= acc_d[b];
      end
    end
  end

  assign oValid_BM_WS = out_valid_q;
  assign oData_BM_WS  = out_data_q;

endmodule

// File: tb/tb_mac_folded.sv
// Directed bench for mac_folded: three instances (plain, ReLU, SHIFT=2) share
// one stimulus stream so every vector exercises all finishing variants.
module tb_mac_folded;

  localparam int SA = 4;
  localparam int SB = 2;
  localparam int LN = 2;
  localparam int W  = 4;
  localparam int OW = 8;

  logic              iCLK = 1'b0;
  logic              iRST;
  logic              iValid_AM_W, iValid_AM_S, iReady_BM_WS;
  logic [SB*LN*W-1:0] iData_AM_W;
  logic [LN*W-1:0]   iData_AM_S;

  logic              oReady_AM_W, oReady_AM_S, oValid_BM_WS;
  logic [SB*OW-1:0]  oData_BM_WS;
  logic              r_ready_w, r_ready_s, r_valid;
  logic [SB*OW-1:0]  r_data;
  logic              s_ready_w, s_ready_s, s_valid;
  logic [SB*OW-1:0]  s_data;

  int tests = 0;
  int fails = 0;
  int handoffs = 0;
  int snap;

  mac_folded #(.SIZE_A(SA), .SIZE_B(SB), .LANES(LN), .WIDTH(W), .OWIDTH(OW),
               .SHIFT(0), .RELU(0)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iValid_AM_W(iValid_AM_W), .oReady_AM_W(oReady_AM_W), .iData_AM_W(iData_AM_W),
    .iValid_AM_S(iValid_AM_S), .oReady_AM_S(oReady_AM_S), .iData_AM_S(iData_AM_S),
    .oValid_BM_WS(oValid_BM_WS), .iReady_BM_WS(iReady_BM_WS), .oData_BM_WS(oData_BM_WS)
  );

  mac_folded #(.SIZE_A(SA), .SIZE_B(SB), .LANES(LN), .WIDTH(W), .OWIDTH(OW),
               .SHIFT(0), .RELU(1)) dut_relu (
    .iCLK(iCLK), .iRST(iRST),
    .iValid_AM_W(iValid_AM_W), .oReady_AM_W(r_ready_w), .iData_AM_W(iData_AM_W),
    .iValid_AM_S(iValid_AM_S), .oReady_AM_S(r_ready_s), .iData_AM_S(iData_AM_S),
    .oValid_BM_WS(r_valid), .iReady_BM_WS(iReady_BM_WS), .oData_BM_WS(r_data)
  );

  mac_folded #(.SIZE_A(SA), .SIZE_B(SB), .LANES(LN), .WIDTH(W), .OWIDTH(OW),
               .SHIFT(2), .RELU(0)) dut_shift (
    .iCLK(iCLK), .iRST(iRST),
    .iValid_AM_W(iValid_AM_W), .oReady_AM_W(s_ready_w), .iData_AM_W(iData_AM_W),
    .iValid_AM_S(iValid_AM_S), .oReady_AM_S(s_ready_s), .iData_AM_S(iData_AM_S),
    .oValid_BM_WS(s_valid), .iReady_BM_WS(iReady_BM_WS), .oData_BM_WS(s_data)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) begin
    if (oValid_BM_WS && iReady_BM_WS) handoffs <= handoffs + 1;
  end

  // Weights: row0 lane0, row0 lane1, row1 lane0, row1 lane1.
  function automatic logic [15:0] pw(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [7:0] ps(input int a, input int b);
    return {4'(b), 4'(a)};
  endfunction

  function automatic logic [15:0] po(input int r0, input int r1);
    return {8'(r1), 8'(r0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called and returns at posedge+1; presents one beat and waits for its acceptance.
  task automatic beat(input string tag, input logic [15:0] w, input logic [7:0] s);
    int n = 0;
    iData_AM_W  = w;
    iData_AM_S  = s;
    iValid_AM_W = 1'b1;
    iValid_AM_S = 1'b1;
    #1;
    while (!(oReady_AM_W && oReady_AM_S) && n < 20) begin
      @(posedge iCLK); #1;
      n++;
    end
    if (n >= 20) check({tag, " accept timeout"}, {30'd0, oReady_AM_W, oReady_AM_S}, 32'd3);
    @(posedge iCLK); #1;
    iValid_AM_W = 1'b0;
    iValid_AM_S = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST = 1'b0; iValid_AM_W = 1'b0; iValid_AM_S = 1'b0; iReady_BM_WS = 1'b0;
    iData_AM_W = '0; iData_AM_S = '0;
    #3;
    check("reset valid", {31'd0, oValid_BM_WS}, 32'd0);
    check("reset data", {16'd0, oData_BM_WS}, 32'd0);
    @(negedge iCLK); @(negedge iCLK);
    iRST = 1'b1;
    @(posedge iCLK); #1;

    // Join handshake: one stream alone is never consumed.
    iValid_AM_S = 1'b1;
    iData_AM_S  = ps(7, 7);
    iData_AM_W  = pw(7, 7, 7, 7);
    #1;
    check("join ready w/s", {30'd0, oReady_AM_W, oReady_AM_S}, 32'd2);
    @(posedge iCLK); #1;
    iValid_AM_S = 1'b0;
    iReady_BM_WS = 1'b1;

    // 1. Basic dot product.
    beat("t1 b1", pw(1, 1, 1, 1), ps(1, 2));
    check("t1 valid after b1", {31'd0, oValid_BM_WS}, 32'd0);
    beat("t1 b2", pw(1, 1, 1, 1), ps(3, 4));
    check("t1 valid", {31'd0, oValid_BM_WS}, 32'd1);
    check("t1 data", {16'd0, oData_BM_WS}, {16'd0, po(10, 10)});
    check("t1 relu data", {16'd0, r_data}, {16'd0, po(10, 10)});
    check("t1 shift data", {16'd0, s_data}, {16'd0, po(3, 3)});
    @(posedge iCLK); #1;
    check("t1 valid drops", {31'd0, oValid_BM_WS}, 32'd0);

    // 2. Saturation.
    beat("t2a b1", pw(7, 7, 7, 7), ps(7, 7));
    beat("t2a b2", pw(7, 7, 7, 7), ps(7, 7));
    check("t2 sat hi", {16'd0, oData_BM_WS}, {16'd0, po(127, 127)});
    check("t2 shift 196", {16'd0, s_data}, {16'd0, po(49, 49)});
    beat("t2b b1", pw(-8, -8, -8, -8), ps(7, 7));
    beat("t2b b2", pw(-8, -8, -8, -8), ps(7, 7));
    check("t2 sat lo", {16'd0, oData_BM_WS}, {16'd0, po(-128, -128)});
    check("t2 shift -224", {16'd0, s_data}, {16'd0, po(-56, -56)});
    check("t2 relu lo", {16'd0, r_data}, {16'd0, po(0, 0)});

    // 3. ReLU.
    beat("t3 b1", pw(-1, -1, -1, -1), ps(1, 2));
    beat("t3 b2", pw(-1, -1, -1, -1), ps(3, 4));
    check("t3 relu", {16'd0, r_data}, {16'd0, po(0, 0)});
    check("t3 plain", {16'd0, oData_BM_WS}, {16'd0, po(-10, -10)});
    check("t3 relu valid", {31'd0, r_valid}, 32'd1);

    // 4. Rounding: row sums +10 and -10.
    beat("t4 b1", pw(1, 1, -1, -1), ps(1, 2));
    beat("t4 b2", pw(1, 1, -1, -1), ps(3, 4));
    check("t4 round", {16'd0, s_data}, {16'd0, po(3, -2)});
    check("t4 plain", {16'd0, oData_BM_WS}, {16'd0, po(10, -10)});
    check("t4 relu", {16'd0, r_data}, {16'd0, po(10, 0)});
    @(posedge iCLK); #1;
    check("t4 idle valid", {31'd0, oValid_BM_WS}, 32'd0);

    // 5. Backpressure over three back-to-back vectors.
    snap = handoffs;
    iReady_BM_WS = 1'b0;
    beat("t5 v1 b1", pw(1, 1, 1, 1), ps(1, 1));
    beat("t5 v1 b2", pw(1, 1, 1, 1), ps(1, 1));
    check("t5 v1 data", {16'd0, oData_BM_WS}, {16'd0, po(4, 4)});
    beat("t5 v2 b1", pw(1, 1, 1, 1), ps(1, 2));
    check("t5 v1 held", {16'd0, oData_BM_WS}, {16'd0, po(4, 4)});
    iData_AM_S = ps(1, 2); iValid_AM_W = 1'b1; iValid_AM_S = 1'b1;
    #1;
    check("t5 v2 last stalls", {30'd0, oReady_AM_W, oReady_AM_S}, 32'd0);
    @(posedge iCLK); #1;
    check("t5 still stalled", {30'd0, oReady_AM_W, oReady_AM_S}, 32'd0);
    check("t5 hold valid", {31'd0, oValid_BM_WS}, 32'd1);
    check("t5 hold data", {16'd0, oData_BM_WS}, {16'd0, po(4, 4)});
    iReady_BM_WS = 1'b1;
    #1;
    check("t5 release ready", {30'd0, oReady_AM_W, oReady_AM_S}, 32'd3);
    @(posedge iCLK); #1;
    iReady_BM_WS = 1'b0;
    check("t5 v2 valid", {31'd0, oValid_BM_WS}, 32'd1);
    check("t5 v2 data", {16'd0, oData_BM_WS}, {16'd0, po(6, 6)});
    beat("t5 v3 b1", pw(1, 1, 1, 1), ps(2, 2));
    check("t5 v2 held", {16'd0, oData_BM_WS}, {16'd0, po(6, 6)});
    iData_AM_S = ps(2, 2); iValid_AM_W = 1'b1; iValid_AM_S = 1'b1;
    #1;
    check("t5 v3 last stalls", {30'd0, oReady_AM_W, oReady_AM_S}, 32'd0);
    iReady_BM_WS = 1'b1;
    @(posedge iCLK); #1;
    iValid_AM_W = 1'b0; iValid_AM_S = 1'b0;
    check("t5 v3 data", {16'd0, oData_BM_WS}, {16'd0, po(8, 8)});
    @(posedge iCLK); #1;
    check("t5 v3 drained", {31'd0, oValid_BM_WS}, 32'd0);
    check("t5 handoffs", handoffs - snap, 32'd3);

    // 6. Asynchronous reset mid-vector.
    iReady_BM_WS = 1'b0;
    beat("t6 v1 b1", pw(1, 1, 1, 1), ps(1, 1));
    beat("t6 v1 b2", pw(1, 1, 1, 1), ps(2, 2));
    check("t6 pre data", {16'd0, oData_BM_WS}, {16'd0, po(6, 6)});
    beat("t6 partial", pw(1, 1, 1, 1), ps(5, 5));
    #3;
    iRST = 1'b0;
    #1;
    check("t6 async valid", {31'd0, oValid_BM_WS}, 32'd0);
    check("t6 async data", {16'd0, oData_BM_WS}, 32'd0);
    check("t6 async shift data", {16'd0, s_data}, 32'd0);
    @(negedge iCLK); @(negedge iCLK);
    iRST = 1'b1;
    iReady_BM_WS = 1'b1;
    @(posedge iCLK); #1;
    beat("t6 fresh b1", pw(1, 1, 1, 1), ps(1, 1));
    check("t6 fresh mid valid", {31'd0, oValid_BM_WS}, 32'd0);
    beat("t6 fresh b2", pw(1, 1, 1, 1), ps(1, 1));
    check("t6 fresh valid", {31'd0, oValid_BM_WS}, 32'd1);
    check("t6 fresh data", {16'd0, oData_BM_WS}, {16'd0, po(4, 4)});
    check("t6 fresh shift", {16'd0, s_data}, {16'd0, po(1, 1)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
